// File: rtl/led_sweep_scheduler_if.sv
// Bus bundle between the LED sweep scheduler and whoever drives it.
// The controller side (switches, prescaler tick, step period, soft clear)
// uses the master modport; the scheduler uses the slave modport.
interface led_sweep_scheduler_if #(
    parameter int N_LEDS = 4,
    parameter int CNT_W  = 8
);
    logic              tick;
    logic [2:0]        sw;
    logic [CNT_W-1:0]  period;
    logic              clr;
    logic [N_LEDS-1:0] led;
    logic              dir;
    logic              paused;
    logic              step_pulse;

    modport master (
        output tick, sw, period, clr,
        input  led, dir, paused, step_pulse
    );

    modport slave (
        input  tick, sw, period, clr,
        output led, dir, paused, step_pulse
    );
endinterface

// File: rtl/led_sweep_scheduler.sv
// LED chaser sequencer.
// Raw mode switches are synchronised (2 flops) and debounced (DEB_CYCLES
// consecutive disagreeing cycles), then decoded into forward / reverse /
// hold commands. One FSM (IDLE, RUN, PAUSE) owns the LED position, the
// direction and the tick divider; all outputs are registered.
// Build option: define LED_SWEEP_BOUNCE_EN for ping-pong stepping (the
// sweep turns around at either end of the ring instead of wrapping).
module led_sweep_scheduler #(
    parameter int N_LEDS     = 4,
    parameter int CNT_W      = 8,
    parameter int DEB_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    led_sweep_scheduler_if.slave sched_if
);

    localparam int POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    // One step along the ring: returns {new_dir, new_pos}. In ping-pong
    // builds the direction flips when the step leaves an end LED.
    function automatic logic [POS_W:0] advance(input logic [POS_W-1:0] pos,
                                               input logic             fwd);
        logic [POS_W-1:0] nxt;
        logic             nfwd;
        nfwd = fwd;
`ifdef LED_SWEEP_BOUNCE_EN
        if (fwd) begin
            if (pos == POS_LAST) begin
                nxt  = POS_LAST - POS_W'(1);
                nfwd = 1'b0;
            end else begin
                nxt = pos + POS_W'(1);
            end
        end else begin
            if (pos == '0) begin
                nxt  = POS_W'(1);
                nfwd = 1'b1;
            end else begin
                nxt = pos - POS_W'(1);
            end
        end
`else
        if (fwd) begin
            if (pos == POS_LAST) begin
                nxt = '0;
            end else begin
                nxt = pos + POS_W'(1);
            end
        end else begin
            if (pos == '0) begin
                nxt = POS_LAST;
            end else begin
                nxt = pos - POS_W'(1);
            end
        end
`endif
        return {nfwd, nxt};
    endfunction

    // One-hot LED pattern for a ring position.
    function automatic logic [N_LEDS-1:0] onehot(input logic [POS_W-1:0] pos);
        logic [N_LEDS-1:0] one;
        one = {{(N_LEDS-1){1'b0}}, 1'b1};
        return one << pos;
    endfunction

    // ---------------------------------------------------------------
    // Switch input path
    // ---------------------------------------------------------------
    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [2:0]       deb_q;
    logic [2:0]       deb_d;
    logic [DEB_W-1:0] deb_cnt_q [3];
    logic [DEB_W-1:0] deb_cnt_d [3];
    logic [1:0]       deb_prev_q;

    // Debounce: accept a new switch value only after DEB_CYCLES consecutive
    // cycles of disagreement; any agreeing cycle restarts the count.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 3; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i]     = sync2_q[i];
                    deb_cnt_d[i] = '0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
                end
            end else begin
                deb_cnt_d[i] = '0;
            end
        end
    end

    // Synchroniser and debounce registers; only rst clears them, so a soft
    // clear does not restart the switch filtering.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 3'b000;
            sync2_q    <= 3'b000;
            deb_q      <= 3'b000;
            deb_prev_q <= 2'b00;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= sched_if.sw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q[1:0];
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    // ---------------------------------------------------------------
    // Command decode
    // ---------------------------------------------------------------
    logic cmd_fwd_s;
    logic cmd_rev_s;
    logic cmd_none_s;
    logic hold_s;
    logic cmd_edge_s;

    assign cmd_fwd_s  = deb_q[0] & ~deb_q[1];
    assign cmd_rev_s  = ~deb_q[0] & deb_q[1];
    assign cmd_none_s = (deb_q[0] == deb_q[1]);
    assign hold_s     = deb_q[2] | cmd_none_s;
    // A fresh fwd/rev decode; only this may override the running direction,
    // so a ping-pong turn-around is not undone by a steadily held switch.
    assign cmd_edge_s = (deb_q[1:0] != deb_prev_q);

    // ---------------------------------------------------------------
    // Sequencer FSM
    // ---------------------------------------------------------------
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [POS_W-1:0]  pos_q;
    logic [POS_W-1:0]  pos_d;
    logic [CNT_W-1:0]  div_cnt_q;
    logic [CNT_W-1:0]  div_cnt_d;
    logic              dir_q;
    logic              dir_d;
    logic [N_LEDS-1:0] led_q;
    logic [N_LEDS-1:0] led_d;
    logic              paused_q;
    logic              paused_d;
    logic              step_pulse_q;
    logic              step_s;
    logic [POS_W:0]    adv_s;

    assign adv_s = advance(pos_q, dir_q);

    // Next-state logic: hold beats stepping, and a tick seen in PAUSE or in
    // the cycle that enters PAUSE is dropped.
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        div_cnt_d = div_cnt_q;
        dir_d     = dir_q;
        step_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fwd_s && !deb_q[2]) begin
                    state_d   = ST_RUN;
                    dir_d     = 1'b1;
                    pos_d     = '0;
                    div_cnt_d = '0;
                end else if (cmd_rev_s && !deb_q[2]) begin
                    state_d   = ST_RUN;
                    dir_d     = 1'b0;
                    pos_d     = POS_LAST;
                    div_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (hold_s) begin
                    state_d = ST_PAUSE;
                end else begin
                    if (sched_if.tick) begin
                        if (div_cnt_q >= sched_if.period) begin
                            step_s    = 1'b1;
                            div_cnt_d = '0;
                            pos_d     = adv_s[POS_W-1:0];
                            dir_d     = adv_s[POS_W];
                        end else begin
                            div_cnt_d = div_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        div_cnt_d = div_cnt_q;
                    end
                    // Switch edge takes precedence over an internal turn-around.
                    if (cmd_edge_s) begin
                        dir_d = cmd_fwd_s;
                    end else begin
                        dir_d = dir_d;
                    end
                end
            end
            ST_PAUSE: begin
                if (!hold_s) begin
                    state_d = ST_RUN;
                    dir_d   = cmd_fwd_s;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pos_d     = '0;
                div_cnt_d = '0;
                dir_d     = 1'b1;
            end
        endcase
    end

    // Output decode from the next state so LEDs and flags line up with it.
    always_comb begin
        led_d    = '0;
        paused_d = 1'b0;
        if (state_d == ST_IDLE) begin
            led_d = '0;
        end else begin
            led_d = onehot(pos_d);
        end
        if (state_d == ST_PAUSE) begin
            paused_d = 1'b1;
        end else begin
            paused_d = 1'b0;
        end
    end

    // FSM state and registered outputs; soft clear behaves like reset here.
    always_ff @(posedge clk) begin
        if (rst || sched_if.clr) begin
            state_q      <= ST_IDLE;
            pos_q        <= '0;
            div_cnt_q    <= '0;
            dir_q        <= 1'b1;
            led_q        <= '0;
            paused_q     <= 1'b0;
            step_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            div_cnt_q    <= div_cnt_d;
            dir_q        <= dir_d;
            led_q        <= led_d;
            paused_q     <= paused_d;
            step_pulse_q <= step_s;
        end
    end

    assign sched_if.led        = led_q;
    assign sched_if.dir        = dir_q;
    assign sched_if.paused     = paused_q;
    assign sched_if.step_pulse = step_pulse_q;

endmodule

// File: tb/tb_led_sweep_scheduler.sv
// Directed bench for led_sweep_scheduler (N_LEDS=4, CNT_W=8, DEB_CYCLES=16).
// Inputs change and outputs are sampled on the falling clock edge.
// Expected LED sequences follow the build: LED_SWEEP_BOUNCE_EN selects the
// ping-pong tables.
module tb_led_sweep_scheduler;

    localparam int N_LEDS     = 4;
    localparam int CNT_W      = 8;
    localparam int DEB_CYCLES = 16;

`ifdef LED_SWEEP_BOUNCE_EN
    localparam logic [3:0] T1 [4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0100};
    localparam logic [3:0] T5_WRAP = 4'b0010;
    localparam logic [3:0] T8 [8]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                       4'b0010, 4'b0001, 4'b0010, 4'b0100};
`else
    localparam logic [3:0] T1 [4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    localparam logic [3:0] T5_WRAP = 4'b1000;
    localparam logic [3:0] T8 [8]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                       4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    localparam logic [3:0] T2 [7]  = '{4'b1000, 4'b1000, 4'b0100, 4'b0100,
                                       4'b0100, 4'b0010, 4'b0010};
    localparam logic       P2 [7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    logic clk = 1'b0;
    logic rst;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   pulse_cnt = 0;
    int   pc0       = 0;

    led_sweep_scheduler_if #(.N_LEDS(N_LEDS), .CNT_W(CNT_W)) bus ();

    led_sweep_scheduler #(
        .N_LEDS     (N_LEDS),
        .CNT_W      (CNT_W),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sched_if (bus)
    );

    always #5 clk = ~clk;

    // Running count of step pulses seen on the output.
    always @(posedge clk) begin
        if (bus.step_pulse) begin
            pulse_cnt <= pulse_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tick();
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
    endtask

    initial begin
        bus.tick   = 1'b0;
        bus.sw     = 3'b000;
        bus.period = 8'd0;
        bus.clr    = 1'b0;
        rst        = 1'b1;
        cyc(2);
        rst = 1'b0;
        check("reset_led", bus.led, 4'b0000);
        check("reset_dir", bus.dir, 1'b1);
        check("reset_paused", bus.paused, 1'b0);
        check("reset_step_pulse", bus.step_pulse, 1'b0);

        // Bouncing fwd switch: 5-cycle runs never reach the 16-cycle filter.
        for (int k = 0; k < 12; k++) begin
            bus.sw[0] = ~bus.sw[0];
            cyc(5);
            check("bounce_idle_led", bus.led, 4'b0000);
        end
        cyc(25);
        check("bounce_settled_led", bus.led, 4'b0000);
        check("bounce_settled_paused", bus.paused, 1'b0);

        // Forward start: first LED lights 2+16+1 cycles after the switch.
        bus.sw = 3'b001;
        cyc(18);
        check("fwd_latency_dark", bus.led, 4'b0000);
        cyc(1);
        check("fwd_entry_led", bus.led, 4'b0001);
        check("fwd_entry_dir", bus.dir, 1'b1);
        check("fwd_entry_pulse", bus.step_pulse, 1'b0);
        pc0 = pulse_cnt;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            pulse_tick();
            check("fwd_step_led", bus.led, T1[k]);
            check("fwd_step_pulse", bus.step_pulse, 1'b1);
        end
        cyc(2);
        check("fwd_pulse_count", pulse_cnt - pc0, 4);

        // Reach LED1 going forward, then flip to reverse without a hold gap.
        pulse_tick();
        check("pre_flip_led", bus.led, 4'b0010);
        bus.sw = 3'b010;
        cyc(20);
        check("flip_dir", bus.dir, 1'b0);
        check("flip_led_kept", bus.led, 4'b0010);
        check("flip_not_paused", bus.paused, 1'b0);
        pulse_tick();
        check("rev_step_led", bus.led, 4'b0001);
        cyc(1);
        pulse_tick();
        check("rev_wrap_led", bus.led, T5_WRAP);

        // Soft clear mid-run, then immediate reverse re-entry with period=2.
        cyc(1);
        bus.clr    = 1'b1;
        bus.period = 8'd2;
        @(negedge clk);
        bus.clr = 1'b0;
        check("clr_led", bus.led, 4'b0000);
        check("clr_dir", bus.dir, 1'b1);
        check("clr_paused", bus.paused, 1'b0);
        cyc(1);
        check("rev_entry_led", bus.led, 4'b1000);
        check("rev_entry_dir", bus.dir, 1'b0);
        for (int k = 0; k < 7; k++) begin
            cyc(1);
            pulse_tick();
            check("div3_led", bus.led, T2[k]);
            check("div3_pulse", bus.step_pulse, P2[k]);
        end

        // Back to forward with period lowered below the divider count.
        bus.period = 8'd0;
        bus.sw     = 3'b001;
        cyc(20);
        check("refwd_dir", bus.dir, 1'b1);
        check("refwd_led", bus.led, 4'b0010);
        pulse_tick();
        check("lowered_period_led", bus.led, 4'b0100);
        bus.period = 8'd2;
        cyc(1);
        pulse_tick();
        check("pre_pause_led", bus.led, 4'b0100);

        // Pause: LEDs and divider frozen while ticks keep arriving.
        bus.sw = 3'b101;
        cyc(20);
        check("pause_flag", bus.paused, 1'b1);
        check("pause_led", bus.led, 4'b0100);
        for (int k = 0; k < 4; k++) begin
            cyc(6);
            pulse_tick();
            check("pause_led_frozen", bus.led, 4'b0100);
            check("pause_no_pulse", bus.step_pulse, 1'b0);
        end
        bus.sw = 3'b001;
        cyc(20);
        check("resume_paused", bus.paused, 1'b0);
        check("resume_led", bus.led, 4'b0100);
        check("resume_dir", bus.dir, 1'b1);
        pulse_tick();
        check("resume_tick1_led", bus.led, 4'b0100);
        cyc(1);
        pulse_tick();
        check("resume_tick2_led", bus.led, 4'b1000);
        check("resume_tick2_pulse", bus.step_pulse, 1'b1);

        // Eight consecutive single-tick steps from LED0 going forward.
        bus.period = 8'd0;
        bus.clr    = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        check("clr2_led", bus.led, 4'b0000);
        cyc(1);
        check("sweep_entry_led", bus.led, 4'b0001);
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            pulse_tick();
            check("sweep_led", bus.led, T8[k]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
